// File: rtl/raycaster_pkg.sv
// Shared definitions for the raycaster line-buffer read path.
package raycaster_pkg;

  localparam int LINE_DEPTH = 320;
  localparam int PIXEL_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/line_buffer_reader_skid_fifo2.sv
// Two-entry FIFO of {last, data} used as the output skid buffer.
module skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/line_buffer_reader.sv
// Read-side sequencer for the line buffer: sweeps raddr 0..DEPTH-1, absorbs
// the RAM's 1-cycle read latency and streams entries out via valid/ready.
// Optional feature macro: PIXEL_DOUBLE_EN (emit each entry twice).
module line_buffer_reader
  import raycaster_pkg::*;
#(
  parameter int SIZE  = PIXEL_BITS,
  parameter int DEPTH = LINE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [SIZE-1:0]          read_data,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t      state;
  state_t      state_next;
  logic        inflight;
  logic        inflight_last;
  logic        issue;
  logic        pop;
  logic        hs;
  logic        last_hs;
  logic        fifo_empty;
  logic        fifo_full;
  logic [1:0]  fifo_count;
  logic [2:0]  pending;
  logic [SIZE:0] head;

  skid_fifo2 #(.W(SIZE + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, read_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head[SIZE-1:0];
  assign hs        = out_valid & out_ready;
  assign busy      = (state != ST_IDLE);

`ifdef PIXEL_DOUBLE_EN
  logic second;

  // Tracks which copy of the head entry is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second <= 1'b0;
    end else if (hs) begin
      second <= ~second;
    end
  end

  assign pop      = hs & second;
  assign out_last = out_valid & head[SIZE] & second;
`else
  assign pop      = hs;
  assign out_last = out_valid & head[SIZE];
`endif

  assign last_hs = hs & out_last;

  // Credit counts the pop happening this cycle so the FIFO can refill at
  // one entry per cycle while never holding more than two.
  assign pending = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue   = (state == ST_RUN) && !(fifo_full && !pop) &&
                   (pending < (3'd2 + {2'b00, pop}));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (issue && (raddr == LAST_ADDR)) state_next = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // One read in flight: its data lands in the FIFO on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (raddr == LAST_ADDR);
    end
  end

  // Read address: advances on issue, saturates at the final entry, clears in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr <= '0;
    end else if (state_next == ST_IDLE) begin
      raddr <= '0;
    end else if (issue && (raddr != LAST_ADDR)) begin
      raddr <= raddr + AW'(1);
    end
  end

  // Completion pulse the cycle after the final word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= last_hs;
    end
  end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Self-checking bench for line_buffer_reader; RAM modelled as mem[i]=i*3
// with one cycle of read latency.
module tb_line_buffer_reader;

  localparam int DEPTH = 320;
  localparam int SIZE  = 32;
`ifdef PIXEL_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif
  localparam int TOTAL = DEPTH * REP;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic [8:0]      raddr;
  logic [SIZE-1:0] read_data;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;

  int tests = 0;
  int fails = 0;
  int exp_idx;

  line_buffer_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= {23'b0, raddr} * 32'd3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input int k);
    return 32'((k / REP) * 3);
  endfunction

  // Streams words with out_ready at pct% duty until done (plus a short tail).
  task automatic run_stream(input int pct, input int restart_at, input int reset_at,
                            output int words, output int dones, output int done_cyc);
    logic        prev_stall = 1'b0;
    logic [33:0] saved = '0;
    logic        took_last;
    bit          pulsed = 1'b0;
    bit          fin = 1'b0;
    int          tail = -1;
    int          cyc_n = 0;
    dones    = 0;
    done_cyc = -1;
    while (!fin && cyc_n < 8000) begin
      if (reset_at >= 0 && exp_idx == reset_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_last", out_last, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_raddr", raddr, 0);
        chk("rst_mid_done", done, 0);
        fin = 1'b1;
        break;
      end
      start = (restart_at >= 0 && exp_idx == restart_at && !pulsed);
      if (start) pulsed = 1'b1;
      out_ready = ($urandom_range(99) < pct);
      if (prev_stall) chk("stall_stable", {out_valid, out_last, out_data}, saved);
      took_last = 1'b0;
      if (out_valid && out_ready) begin
        chk($sformatf("word%0d", exp_idx), {out_last, out_data},
            {(exp_idx == TOTAL - 1), exp_data(exp_idx)});
        took_last = (exp_idx == TOTAL - 1);
        exp_idx++;
      end
      prev_stall = out_valid && !out_ready;
      saved = {out_valid, out_last, out_data};
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc_n++;
      if (took_last) chk("done_after_last", done, 1);
      if (done) begin
        dones++;
        if (tail < 0) begin
          tail = 4;
          done_cyc = cyc_n;
        end
      end
      if (tail >= 0) begin
        if (tail == 0) fin = 1'b1;
        tail--;
      end
    end
    if (!fin) chk("stream_timeout", 1, 0);
    out_ready = 1'b0;
    words = exp_idx;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] data;
    logic [8:0]  raddr;
  } cyc_vec_t;

  typedef struct {
    int pct;
    int restart_at;
    int reset_at;
    int exp_words;
    int exp_dones;
  } sweep_vec_t;

  cyc_vec_t   cyc[9];
  sweep_vec_t sw[4];

  initial begin
    int words, dones, dcyc;

    cyc[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  9'd0};
    cyc[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  9'd1};
    cyc[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  9'd2};
`ifdef PIXEL_DOUBLE_EN
    cyc[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  9'd2};
    cyc[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd3,  9'd3};
    cyc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3,  9'd3};
    cyc[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3,  9'd3};
    cyc[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd3,  9'd3};
    cyc[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd6,  9'd4};
`else
    cyc[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd3,  9'd3};
    cyc[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd6,  9'd4};
    cyc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd6,  9'd4};
    cyc[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd6,  9'd4};
    cyc[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd9,  9'd5};
    cyc[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 9'd6};
`endif

    sw[0] = '{30,  -1,  -1,  TOTAL, 1};
    sw[1] = '{100, 100, -1,  TOTAL, 1};
    sw[2] = '{60,  -1,  150, 150,   0};
    sw[3] = '{100, -1,  -1,  TOTAL, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_raddr", raddr, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Startup latency and early backpressure, cycle by cycle
    for (int i = 0; i < 9; i++) begin
      start     = cyc[i].start;
      out_ready = cyc[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("cyc%0d_busy", i), busy, cyc[i].busy);
      chk($sformatf("cyc%0d_valid", i), out_valid, cyc[i].valid);
      chk($sformatf("cyc%0d_raddr", i), raddr, cyc[i].raddr);
      if (cyc[i].valid) chk($sformatf("cyc%0d_data", i), out_data, cyc[i].data);
    end
    start   = 1'b0;
    exp_idx = 4;
    run_stream(100, -1, -1, words, dones, dcyc);
    chk("t1_words", words, TOTAL);
    chk("t1_dones", dones, 1);
    chk("t1_rate", dcyc, TOTAL - 4);

    // Sink stalled for 10 cycles straight after start
    start     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 0);
    chk("stall_raddr", raddr, 2);
    chk("stall_count", u_dut.u_fifo.count, 2);
    exp_idx = 0;
    run_stream(100, -1, -1, words, dones, dcyc);
    chk("t3_words", words, TOTAL);
    chk("t3_dones", dones, 1);

    // Random backpressure, restart-while-busy, reset mid-sweep, fresh sweep
    for (int s = 0; s < 4; s++) begin
      if (!rst_n) begin
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      start     = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      start   = 1'b0;
      exp_idx = 0;
      run_stream(sw[s].pct, sw[s].restart_at, sw[s].reset_at, words, dones, dcyc);
      chk($sformatf("sweep%0d_words", s), words, sw[s].exp_words);
      chk($sformatf("sweep%0d_dones", s), dones, sw[s].exp_dones);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
